serial_byte_receiver: RTL

- Receives an asynchronous serial stream (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit) and deserializes it into a byte.
- Sits directly upstream of the 8-bit Avalon parallel input port: data_out drives that port's in_port. Status flags drive spare PIO inputs for CPU polling.
- The CPU acknowledges each byte via rx_ack, driven from a PIO output.

---
 rtl/serial_byte_receiver.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/serial_byte_receiver.sv
// Asynchronous serial receiver (8N1 by default): deserializes one byte per frame
// for a PIO in_port. Define SERIAL_RX_PARITY_EN to add an even-parity bit and parity_error.
module serial_byte_receiver #(
  parameter int CLKS_PER_BIT = 16  // must be >= 4 and even
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       serial_in,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_error,
  output logic       overrun,
`ifdef SERIAL_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cycleCnt_q, cycleCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, sync2_q, rxPrev_q;
  logic [7:0]    dataOut_q, dataOut_d;
  logic          dataReady_q, dataReady_d;
  logic          frameErr_q, frameErr_d;
  logic          overrun_q, overrun_d;
  logic          rxS, rxFall;
  logic          loadByte, setFrameErr;
`ifdef SERIAL_RX_PARITY_EN
  logic          parBit_q, parBit_d;
  logic          parErr_q, parErr_d;
  logic          parOk, setParErr;
`endif

  // Two-flop synchronizer plus a third flop for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      sync1_q  <= serial_in;
      sync2_q  <= sync1_q;
      rxPrev_q <= sync2_q;
    end
  end

  assign rxS    = sync2_q;
  assign rxFall = ~rxS & rxPrev_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parOk  = ~(^shift_q ^ parBit_q);
`endif

  always_comb begin
    state_d     = state_q;
    cycleCnt_d  = cycleCnt_q;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    loadByte    = 1'b0;
    setFrameErr = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    parBit_d    = parBit_q;
    setParErr   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rxFall) begin
          state_d    = START;
          cycleCnt_d = '0;
        end
      end
      START: begin
        // Re-check the line mid start bit so short glitches are rejected
        if (cycleCnt_q == HALF_LAST) begin
          cycleCnt_d = '0;
          bitIdx_d   = '0;
          state_d    = rxS ? IDLE : DATA;
        end else begin
          cycleCnt_d = cycleCnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cycleCnt_q == FULL_LAST) begin
          cycleCnt_d        = '0;
          shift_d[bitIdx_q] = rxS;
          bitIdx_d          = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cycleCnt_d = cycleCnt_q + 1'b1;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (cycleCnt_q == FULL_LAST) begin
          cycleCnt_d = '0;
          parBit_d   = rxS;
          state_d    = STOP;
        end else begin
          cycleCnt_d = cycleCnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cycleCnt_q == FULL_LAST) begin
          cycleCnt_d  = '0;
          state_d     = IDLE;
          setFrameErr = ~rxS;
`ifdef SERIAL_RX_PARITY_EN
          setParErr   = ~parOk;
          loadByte    = rxS & parOk;
`else
          loadByte    = rxS;
`endif
        end else begin
          cycleCnt_d = cycleCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A load in the same cycle as rx_ack wins, and the ack cancels any overrun
  always_comb begin
    dataOut_d   = loadByte ? shift_q : dataOut_q;
    dataReady_d = loadByte | (dataReady_q & ~rx_ack);
    overrun_d   = (overrun_q & ~rx_ack) | (loadByte & dataReady_q & ~rx_ack);
    frameErr_d  = (frameErr_q & ~rx_ack) | setFrameErr;
`ifdef SERIAL_RX_PARITY_EN
    parErr_d    = (parErr_q & ~rx_ack) | setParErr;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cycleCnt_q  <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      dataOut_q   <= '0;
      dataReady_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parBit_q    <= 1'b0;
      parErr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cycleCnt_q  <= cycleCnt_d;
      bitIdx_q    <= bitIdx_d;
      shift_q     <= shift_d;
      dataOut_q   <= dataOut_d;
      dataReady_q <= dataReady_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
      parBit_q    <= parBit_d;
      parErr_q    <= parErr_d;
`endif
    end
  end

  assign data_out     = dataOut_q;
  assign data_ready   = dataReady_q;
  assign frame_error  = frameErr_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);
`ifdef SERIAL_RX_PARITY_EN
  assign parity_error = parErr_q;
`endif

endmodule
